// File: rtl/toy_vpack.sv
// rtl/toy_vpack.sv - shared vector widths, unit select and decoded instruction type
package toy_vpack;

  localparam int V_ELEMENT_NUM   = 8;
  localparam int V_OPC_WIDTH     = 7;
  localparam int V_REG_IDX_WIDTH = 5;
  localparam int V_REG_NUM       = 1 << V_REG_IDX_WIDTH;

  typedef enum logic [1:0] {
    V_UNIT_MTX = 2'd0,
    V_UNIT_ALU = 2'd1,
    V_UNIT_LSU = 2'd2,
    V_UNIT_RSV = 2'd3
  } v_unit_e;

  typedef struct packed {
    v_unit_e                    unit;
    logic [V_OPC_WIDTH-1:0]     opcode;
    logic [V_REG_IDX_WIDTH-1:0] vs1;
    logic [V_REG_IDX_WIDTH-1:0] vs2;
    logic [V_REG_IDX_WIDTH-1:0] rd;
    logic                       vd_wr;
  } v_instr_t;

endpackage

// File: rtl/toy_vissue_fifo.sv
// rtl/toy_vissue_fifo.sv - synchronous FIFO of decoded vector instructions
module toy_vissue_fifo
  import toy_vpack::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  v_instr_t      push_data,
  input  logic          pop,
  output v_instr_t      head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  v_instr_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/toy_vissue.sv
// rtl/toy_vissue.sv - in-order vector issue with register scoreboard and matrix occupancy
module toy_vissue
  import toy_vpack::*;
#(
  parameter int QUEUE_DEPTH  = 4,
  parameter int MTX_OCC      = 4,
  parameter int LSU_LAT      = 3,
  parameter int SB_CNT_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_vld,
  output logic                       instr_rdy,
  input  logic [1:0]                 instr_unit,
  input  logic [V_OPC_WIDTH-1:0]     instr_opcode,
  input  logic [V_REG_IDX_WIDTH-1:0] instr_vs1,
  input  logic [V_REG_IDX_WIDTH-1:0] instr_vs2,
  input  logic [V_REG_IDX_WIDTH-1:0] instr_rd,
  input  logic                       instr_vd_wr,
  output logic                       vmtx_op_en,
  output logic [V_OPC_WIDTH-1:0]     vmtx_opcode,
  output logic [V_REG_IDX_WIDTH-1:0] vmtx_vs1,
  output logic [V_REG_IDX_WIDTH-1:0] vmtx_vs2,
  output logic                       valu_op_en,
  output logic [V_OPC_WIDTH-1:0]     valu_opcode,
  output logic [V_REG_IDX_WIDTH-1:0] valu_vs1,
  output logic [V_REG_IDX_WIDTH-1:0] valu_vs2,
  output logic [4:0]                 valu_rd,
  output logic                       vlsu_op_en,
  output logic [V_OPC_WIDTH-1:0]     vlsu_opcode,
  output logic [V_REG_IDX_WIDTH-1:0] vlsu_vs1,
  output logic [V_REG_IDX_WIDTH-1:0] vlsu_vs2,
  output logic [V_REG_IDX_WIDTH-1:0] vlsu_rd,
  output logic                       idle
);

  localparam int CW = $clog2(QUEUE_DEPTH);
  localparam int MW = (MTX_OCC > 1) ? $clog2(MTX_OCC) : 1;
  localparam logic [MW-1:0]           MTX_LOAD = MW'(MTX_OCC - 1);
  localparam logic [SB_CNT_WIDTH-1:0] SB_LOAD  = SB_CNT_WIDTH'(LSU_LAT);
  localparam logic [SB_CNT_WIDTH-1:0] SB_ONE   = SB_CNT_WIDTH'(1);

  v_instr_t                  in_instr;
  v_instr_t                  head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CW:0]               fifo_count;
  logic                      fifo_pop;

  logic [SB_CNT_WIDTH-1:0]   sb [V_REG_NUM];
  logic [MW-1:0]             mtx_cnt;
  logic                      sb_nz;

  logic                      is_mtx, is_alu, is_lsu, is_rsv;
  logic                      raw, waw, busy;
  logic                      issue_go;
  logic                      sb_load;

  assign in_instr.unit   = v_unit_e'(instr_unit);
  assign in_instr.opcode = instr_opcode;
  assign in_instr.vs1    = instr_vs1;
  assign in_instr.vs2    = instr_vs2;
  assign in_instr.rd     = instr_rd;
  assign in_instr.vd_wr  = instr_vd_wr;

  toy_vissue_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (instr_vld),
    .push_data (in_instr),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_rdy = !fifo_full;

  assign is_mtx = (head.unit == V_UNIT_MTX);
  assign is_alu = (head.unit == V_UNIT_ALU);
  assign is_lsu = (head.unit == V_UNIT_LSU);
  assign is_rsv = (head.unit == V_UNIT_RSV);

  // A count of 1 means the load result lands at the coming edge, so an
  // op issued now already sees it; only counts above 1 are a real hazard.
  assign raw  = (sb[head.vs1] > SB_ONE) || (sb[head.vs2] > SB_ONE);
  assign waw  = is_lsu && head.vd_wr && (sb[head.rd] > SB_ONE);
  assign busy = is_mtx && (mtx_cnt != '0);

  assign issue_go = !fifo_empty && !is_rsv && !raw && !waw && !busy;
  assign fifo_pop = !fifo_empty && (is_rsv || issue_go);
  assign sb_load  = issue_go && is_lsu && head.vd_wr;

  always_comb begin
    sb_nz = 1'b0;
    for (int i = 0; i < V_REG_NUM; i++) begin
      sb_nz = sb_nz | (sb[i] != '0);
    end
  end

  assign idle = (fifo_count == '0) && !sb_nz && (mtx_cnt == '0)
              && !vmtx_op_en && !valu_op_en && !vlsu_op_en;

  // The issuing op's own load wins over the decrement on the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < V_REG_NUM; i++) begin
        sb[i] <= '0;
      end
    end else begin
      for (int i = 0; i < V_REG_NUM; i++) begin
        if (sb_load && (head.rd == V_REG_IDX_WIDTH'(i))) begin
          sb[i] <= SB_LOAD;
        end else if (sb[i] != '0) begin
          sb[i] <= sb[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtx_cnt <= '0;
    end else if (issue_go && is_mtx) begin
      mtx_cnt <= MTX_LOAD;
    end else if (mtx_cnt != '0) begin
      mtx_cnt <= mtx_cnt - 1'b1;
    end
  end

  // Field buses of units not issuing keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vmtx_op_en  <= 1'b0;
      vmtx_opcode <= '0;
      vmtx_vs1    <= '0;
      vmtx_vs2    <= '0;
      valu_op_en  <= 1'b0;
      valu_opcode <= '0;
      valu_vs1    <= '0;
      valu_vs2    <= '0;
      valu_rd     <= '0;
      vlsu_op_en  <= 1'b0;
      vlsu_opcode <= '0;
      vlsu_vs1    <= '0;
      vlsu_vs2    <= '0;
      vlsu_rd     <= '0;
    end else begin
      vmtx_op_en <= issue_go && is_mtx;
      valu_op_en <= issue_go && is_alu;
      vlsu_op_en <= issue_go && is_lsu;
      if (issue_go && is_mtx) begin
        vmtx_opcode <= head.opcode;
        vmtx_vs1    <= head.vs1;
        vmtx_vs2    <= head.vs2;
      end
      if (issue_go && is_alu) begin
        valu_opcode <= head.opcode;
        valu_vs1    <= head.vs1;
        valu_vs2    <= head.vs2;
        valu_rd     <= head.rd[4:0];
      end
      if (issue_go && is_lsu) begin
        vlsu_opcode <= head.opcode;
        vlsu_vs1    <= head.vs1;
        vlsu_vs2    <= head.vs2;
        vlsu_rd     <= head.rd;
      end
    end
  end

endmodule

// File: tb/tb_toy_vissue.sv
// tb/tb_toy_vissue.sv - scoreboard bench for toy_vissue
module tb_toy_vissue;
  import toy_vpack::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       instr_vld;
  logic                       instr_rdy;
  logic [1:0]                 instr_unit;
  logic [V_OPC_WIDTH-1:0]     instr_opcode;
  logic [V_REG_IDX_WIDTH-1:0] instr_vs1, instr_vs2, instr_rd;
  logic                       instr_vd_wr;
  logic                       vmtx_op_en, valu_op_en, vlsu_op_en;
  logic [V_OPC_WIDTH-1:0]     vmtx_opcode, valu_opcode, vlsu_opcode;
  logic [V_REG_IDX_WIDTH-1:0] vmtx_vs1, vmtx_vs2, valu_vs1, valu_vs2;
  logic [V_REG_IDX_WIDTH-1:0] vlsu_vs1, vlsu_vs2, vlsu_rd;
  logic [4:0]                 valu_rd;
  logic                       idle;

  typedef struct {
    int unit;
    int opc;
    int vs1;
    int vs2;
    int rd;
  } exp_t;

  exp_t exp_q[$];
  int   issue_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  toy_vissue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_vld    (instr_vld),
    .instr_rdy    (instr_rdy),
    .instr_unit   (instr_unit),
    .instr_opcode (instr_opcode),
    .instr_vs1    (instr_vs1),
    .instr_vs2    (instr_vs2),
    .instr_rd     (instr_rd),
    .instr_vd_wr  (instr_vd_wr),
    .vmtx_op_en   (vmtx_op_en),
    .vmtx_opcode  (vmtx_opcode),
    .vmtx_vs1     (vmtx_vs1),
    .vmtx_vs2     (vmtx_vs2),
    .valu_op_en   (valu_op_en),
    .valu_opcode  (valu_opcode),
    .valu_vs1     (valu_vs1),
    .valu_vs2     (valu_vs2),
    .valu_rd      (valu_rd),
    .vlsu_op_en   (vlsu_op_en),
    .vlsu_opcode  (vlsu_opcode),
    .vlsu_vs1     (vlsu_vs1),
    .vlsu_vs2     (vlsu_vs2),
    .vlsu_rd      (vlsu_rd),
    .idle         (idle)
  );

  // Issue monitor: every op_en pulse is matched in order against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      int   n;
      exp_t e;
      int   au, aop, av1, av2, ard;
      n = int'(vmtx_op_en) + int'(valu_op_en) + int'(vlsu_op_en);
      if (n > 1) begin
        vectors++; miscompares++;
        $display("FAIL onehot_op_en cyc=%0d got %0d op_en high, want 1", cyc, n);
      end else if (n == 1) begin
        vectors++;
        issue_q.push_back(cyc);
        if (vmtx_op_en) begin
          au = 0; aop = int'(vmtx_opcode); av1 = int'(vmtx_vs1); av2 = int'(vmtx_vs2); ard = 0;
        end else if (valu_op_en) begin
          au = 1; aop = int'(valu_opcode); av1 = int'(valu_vs1); av2 = int'(valu_vs2); ard = int'(valu_rd);
        end else begin
          au = 2; aop = int'(vlsu_opcode); av1 = int'(vlsu_vs1); av2 = int'(vlsu_vs2); ard = int'(vlsu_rd);
        end
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_issue cyc=%0d got unit=%0d opc=%0d, want none", cyc, au, aop);
        end else begin
          e = exp_q.pop_front();
          if (e.unit == 0) e.rd = 0;
          if (au !== e.unit || aop !== e.opc || av1 !== e.vs1 || av2 !== e.vs2 || ard !== e.rd) begin
            miscompares++;
            $display("FAIL issue_fields cyc=%0d got u=%0d op=%0d vs1=%0d vs2=%0d rd=%0d, want u=%0d op=%0d vs1=%0d vs2=%0d rd=%0d",
                     cyc, au, aop, av1, av2, ard, e.unit, e.opc, e.vs1, e.vs2, e.rd);
          end
        end
      end
    end
  end

  task automatic push(input int u, input int opc, input int vs1, input int vs2,
                      input int rd, input bit vdw, output int acc);
    int   b;
    exp_t e;
    instr_unit   = 2'(u);
    instr_opcode = V_OPC_WIDTH'(opc);
    instr_vs1    = V_REG_IDX_WIDTH'(vs1);
    instr_vs2    = V_REG_IDX_WIDTH'(vs2);
    instr_rd     = V_REG_IDX_WIDTH'(rd);
    instr_vd_wr  = vdw;
    instr_vld    = 1'b1;
    if (u != 3) begin
      e.unit = u; e.opc = opc; e.vs1 = vs1; e.vs2 = vs2; e.rd = rd % 32;
      exp_q.push_back(e);
    end
    b = 0;
    while (!instr_rdy && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (b >= 100) begin
      vectors++; miscompares++;
      $display("FAIL rdy_timeout got instr_rdy=0 for 100 cycles, want 1");
    end
    @(negedge clk);
    acc = cyc;
    instr_vld = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    @(negedge clk);
    while (!(idle && exp_q.size() == 0) && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (b >= 200) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout got idle=%0d pending=%0d, want idle=1 pending=0", idle, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({idle, instr_rdy, vmtx_op_en, valu_op_en, vlsu_op_en} !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_ctrl got idle/rdy/op_en=%b, want 11000",
               {idle, instr_rdy, vmtx_op_en, valu_op_en, vlsu_op_en});
    end
    vectors++;
    if ({vmtx_opcode, vmtx_vs1, vmtx_vs2, valu_opcode, valu_vs1, valu_vs2, valu_rd,
         vlsu_opcode, vlsu_vs1, vlsu_vs2, vlsu_rd} !== '0) begin
      miscompares++;
      $display("FAIL reset_buses got nonzero op field bus, want 0");
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_alu();
    int a;
    issue_q.delete();
    push(1, 5, 1, 2, 7, 1'b0, a);
    drain();
    vectors++;
    if (issue_q.size() != 1 || issue_q[0] != a + 1) begin
      miscompares++;
      $display("FAIL alu_latency got n=%0d first=%0d, want n=1 at %0d",
               issue_q.size(), (issue_q.size() > 0) ? issue_q[0] : -1, a + 1);
    end
    vectors++;
    if (idle !== 1'b1) begin
      miscompares++;
      $display("FAIL alu_idle got %b, want 1", idle);
    end
  endtask

  task automatic test_mtx_back_to_back();
    int a0, a1;
    issue_q.delete();
    push(0, 20, 1, 2, 0, 1'b0, a0);
    push(0, 21, 3, 4, 0, 1'b0, a1);
    drain();
    vectors++;
    if (issue_q.size() != 2 || issue_q[0] != a0 + 1 || issue_q[1] - issue_q[0] != 4) begin
      miscompares++;
      $display("FAIL mtx_spacing got n=%0d gap=%0d, want n=2 gap=4",
               issue_q.size(), (issue_q.size() == 2) ? issue_q[1] - issue_q[0] : -1);
    end
  endtask

  task automatic test_lsu_raw();
    int a;
    issue_q.delete();
    push(2, 30, 0, 0, 3, 1'b1, a);
    push(1, 31, 3, 0, 1, 1'b0, a);
    push(1, 32, 4, 0, 2, 1'b0, a);
    drain();
    vectors++;
    if (issue_q.size() != 3 || issue_q[1] - issue_q[0] != 3 || issue_q[2] - issue_q[1] != 1) begin
      miscompares++;
      $display("FAIL raw_spacing got n=%0d, want n=3 gaps 3 and 1", issue_q.size());
    end
  endtask

  task automatic test_waw();
    int a, b;
    issue_q.delete();
    push(2, 40, 0, 0, 2, 1'b1, a);
    push(2, 41, 0, 0, 2, 1'b1, a);
    b = 0;
    while (issue_q.size() < 2 && b < 50) begin
      @(negedge clk);
      #1;
      b++;
    end
    vectors++;
    if (dut.sb[2] !== 3'd3) begin
      miscompares++;
      $display("FAIL waw_sb_reload got sb[2]=%0d, want 3", dut.sb[2]);
    end
    drain();
    vectors++;
    if (issue_q.size() != 2 || issue_q[1] - issue_q[0] != 3) begin
      miscompares++;
      $display("FAIL waw_spacing got n=%0d, want n=2 gap 3", issue_q.size());
    end
  endtask

  task automatic test_self_dep();
    int a;
    issue_q.delete();
    push(2, 45, 6, 6, 6, 1'b1, a);
    drain();
    vectors++;
    if (issue_q.size() != 1 || issue_q[0] != a + 1) begin
      miscompares++;
      $display("FAIL self_dep got n=%0d, want issue at %0d", issue_q.size(), a + 1);
    end
  endtask

  task automatic test_fill_wrap();
    int a, a4, a5;
    issue_q.delete();
    push(0, 50, 0, 0, 0, 1'b0, a);
    push(0, 51, 0, 0, 0, 1'b0, a);
    push(1, 52, 1, 1, 1, 1'b0, a);
    push(1, 53, 2, 2, 2, 1'b0, a);
    push(1, 54, 3, 3, 3, 1'b0, a4);
    vectors++;
    if (instr_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_rdy got %b, want 0", instr_rdy);
    end
    push(1, 55, 4, 4, 4, 1'b0, a5);
    vectors++;
    if (a5 != a4 + 2) begin
      miscompares++;
      $display("FAIL full_accept got edge %0d, want %0d", a5, a4 + 2);
    end
    drain();
  endtask

  task automatic test_reserved();
    int a;
    issue_q.delete();
    push(3, 60, 0, 0, 0, 1'b0, a);
    push(1, 61, 1, 1, 8, 1'b0, a);
    drain();
    vectors++;
    if (issue_q.size() != 1 || issue_q[0] != a + 1) begin
      miscompares++;
      $display("FAIL reserved_drop got n=%0d, want 1 issue at %0d", issue_q.size(), a + 1);
    end
  endtask

  task automatic test_reset_midflight();
    int a;
    issue_q.delete();
    push(2, 70, 0, 0, 9, 1'b1, a);
    push(1, 71, 9, 0, 0, 1'b0, a);
    push(1, 72, 5, 0, 0, 1'b0, a);
    push(1, 73, 5, 0, 0, 1'b0, a);
    vectors++;
    if (exp_q.size() != 3 || dut.sb[9] !== 3'd1) begin
      miscompares++;
      $display("FAIL midflight_state got pending=%0d sb[9]=%0d, want 3 and 1", exp_q.size(), dut.sb[9]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({vmtx_op_en, valu_op_en, vlsu_op_en, idle, instr_rdy} !== 5'b00011) begin
      miscompares++;
      $display("FAIL midflight_reset got op_en/idle/rdy=%b, want 00011",
               {vmtx_op_en, valu_op_en, vlsu_op_en, idle, instr_rdy});
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue_q.delete();
    repeat (10) @(negedge clk);
    vectors++;
    if (issue_q.size() != 0 || idle !== 1'b1) begin
      miscompares++;
      $display("FAIL stale_issue got issues=%0d idle=%b, want 0 and 1", issue_q.size(), idle);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got no finish, want finish");
    $fatal(1);
  end

  initial begin
    instr_vld    = 1'b0;
    instr_unit   = '0;
    instr_opcode = '0;
    instr_vs1    = '0;
    instr_vs2    = '0;
    instr_rd     = '0;
    instr_vd_wr  = 1'b0;
    test_reset();
    test_single_alu();
    test_mtx_back_to_back();
    test_lsu_raw();
    test_waw();
    test_self_dep();
    test_fill_wrap();
    test_reserved();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
